key_hit_scheduler: RTL and testbench

//  Captures player key presses for the rhythm-game lanes. Synchronises and debounces
//  raw active-low buttons, holds one sticky hit flag per lane, and serialises pending

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_debouncer.sv | 58 +++++
 rtl/key_hit_scheduler.sv | 148 ++++++++++++++
 tb/tb_key_hit_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key-hit scheduler: default sizing, offer FSM
// state encoding and a small lane-index wrap helper.
package key_pkg;

    localparam int LANES_DEF    = 4;
    localparam int LANE_W_DEF   = 2;
    localparam int DEBOUNCE_DEF = 16;

    // Offer FSM: IDLE picks the next pending lane, OFFER holds it until accepted.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } offer_state_e;

    // Wraps a lane index into 0..lanes-1 (round-robin search and pointer advance).
    function automatic int lane_wrap(input int idx, input int lanes);
        return idx % lanes;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One lane of key input conditioning: 2-FF synchroniser on the raw active-low
// button, stability counter, and a single-cycle press pulse on the debounced
// released->pressed transition. Release transitions produce no pulse.
module key_debouncer
    import key_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic notRst,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronise, count consecutive disagreeing cycles, flip the debounced level.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; blocking here would let sync2_q see the new
        // sync1_q in the same edge and collapse the synchroniser to one stage.
        if (!notRst) begin
            // NOTE: reset is sampled on the clock edge; "released" is 1 because
            // the buttons are active-low, so a held key after reset still needs
            // a full debounce window before it counts as a press.
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_q   <= sync2_q;
                    cnt_q   <= '0;
                    press_q <= ~sync2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/key_hit_scheduler.sv
// Rhythm-game key capture: per-lane debouncers feed sticky pending flags, a
// round-robin offer FSM serialises hits to the game core over valid/ready, and
// registered LED pulse generators drive the external notS/notR lane latches.
// LANE_W must equal clog2(LANES).
module key_hit_scheduler
    import key_pkg::*;
#(
    parameter int LANES    = LANES_DEF,
    parameter int DEBOUNCE = DEBOUNCE_DEF,
    parameter int LANE_W   = LANE_W_DEF
) (
    input  logic              clk,
    input  logic              notRst,
    input  logic [LANES-1:0]  key_n,
    output logic              hit_valid,
    input  logic              hit_ready,
    output logic [LANE_W-1:0] hit_lane,
    output logic [LANES-1:0]  pending,
    output logic              overflow,
    output logic [LANES-1:0]  led_notS,
    output logic [LANES-1:0]  led_notR
);

    logic [LANES-1:0]  press;
    logic [LANES-1:0]  accept_vec;
    logic [LANES-1:0]  pending_q, pending_d;
    logic [LANES-1:0]  pend_prev_q;
    logic              overflow_q, overflow_d;
    logic [LANES-1:0]  led_notS_q, led_notR_q;
    logic              init_q;
    offer_state_e      state_q;
    logic              hit_valid_q;
    logic [LANE_W-1:0] hit_lane_q;
    logic [LANE_W-1:0] rr_q;
    logic              sel_found;
    logic [LANE_W-1:0] sel_lane;
    logic [LANE_W-1:0] cand;
    logic [LANE_W-1:0] rr_next;
    logic              accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        key_debouncer #(
            .DEBOUNCE(DEBOUNCE)
        ) u_deb (
            .clk    (clk),
            .notRst (notRst),
            .key_n_i(key_n[i]),
            .press_o(press[i])
        );
    end

    assign accept  = hit_valid_q & hit_ready;
    assign rr_next = LANE_W'(lane_wrap(int'(hit_lane_q) + 1, LANES));

    // Pending flag update: press sets, accept clears, press wins on a tie.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would otherwise infer a latch.
        accept_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            accept_vec[i] = accept && (hit_lane_q == LANE_W'(i));
        end
        pending_d  = (pending_q & ~accept_vec) | press;
        overflow_d = |(press & pending_q & ~accept_vec);
    end

    // Round-robin pick: first pending lane at or above rr_q, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_lane  = '0;
        cand      = '0;
        for (int k = 0; k < LANES; k++) begin
            cand = LANE_W'(lane_wrap(int'(rr_q) + k, LANES));
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_lane  = cand;
            end
        end
    end

    // Offer FSM with registered valid/lane and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!notRst) begin
            state_q     <= IDLE;
            hit_valid_q <= 1'b0;
            hit_lane_q  <= '0;
            rr_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        hit_lane_q  <= sel_lane;
                        hit_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    if (hit_ready) begin
                        hit_valid_q <= 1'b0;
                        rr_q        <= rr_next;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    hit_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Pending flags, overflow pulse and LED set/reset pulses one cycle after a flag edge.
    always_ff @(posedge clk) begin
        if (!notRst) begin
            pending_q   <= '0;
            pend_prev_q <= '0;
            overflow_q  <= 1'b0;
            led_notS_q  <= '1;
            led_notR_q  <= '1;
            init_q      <= 1'b1;
        end else begin
            pending_q   <= pending_d;
            pend_prev_q <= pending_q;
            overflow_q  <= overflow_d;
            init_q      <= 1'b0;
            if (init_q) begin
                // First cycle out of reset clears every external latch.
                led_notS_q <= '1;
                led_notR_q <= '0;
            end else begin
                led_notS_q <= ~(pending_q & ~pend_prev_q);
                led_notR_q <= ~(pend_prev_q & ~pending_q);
            end
        end
    end

    // A lane latch must never see set and reset asserted together.
    led_exclusive_a: assert property (@(posedge clk) disable iff (!notRst)
        ((led_notS_q | led_notR_q) == '1));

    assign hit_valid = hit_valid_q;
    assign hit_lane  = hit_lane_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign led_notS  = led_notS_q;
    assign led_notR  = led_notR_q;

endmodule

// File: tb/tb_key_hit_scheduler.sv
// Self-checking bench for key_hit_scheduler: directed scenarios plus a random
// phase, all compared every cycle against a history-based reference model.
module tb_key_hit_scheduler;

    localparam int L  = 4;
    localparam int DB = 16;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          notRst = 1'b0;
    logic [L-1:0]  key_n = '1;
    logic          hit_ready = 1'b0;
    logic          hit_valid;
    logic [LW-1:0] hit_lane;
    logic [L-1:0]  pending;
    logic          overflow;
    logic [L-1:0]  led_notS;
    logic [L-1:0]  led_notR;

    always #5 clk = ~clk;

    key_hit_scheduler #(.LANES(L), .DEBOUNCE(DB), .LANE_W(LW)) dut (
        .clk      (clk),
        .notRst   (notRst),
        .key_n    (key_n),
        .hit_valid(hit_valid),
        .hit_ready(hit_ready),
        .hit_lane (hit_lane),
        .pending  (pending),
        .overflow (overflow),
        .led_notS (led_notS),
        .led_notR (led_notR)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (input/output histories) ----------------
    int           cyc = 0;
    bit           rst_h[$];
    logic [L-1:0] key_h[$];
    logic [L-1:0] pend_h[$];
    bit           m_deb[L];
    int           m_last[L];
    logic [L-1:0] m_press, m_pend, m_ledS, m_ledR;
    bit           m_ovf, m_valid;
    int           m_lane, m_rr;

    // Synchronised level of lane i as seen by the debouncer at edge t.
    function automatic bit sync_at(input int t, input int i);
        if (t < 2) return 1'b1;
        if (rst_h[t-1] || rst_h[t-2]) return 1'b1;
        return key_h[t-2][i];
    endfunction

    function automatic void model_step();
        int t;
        logic [L-1:0] acc, np, pr_n, ls, lr;
        bit ovf_n, v_n, flip;
        int lane_n, rr_n;
        t = cyc;
        rst_h.push_back(!notRst);
        key_h.push_back(key_n);
        if (!notRst) begin
            for (int i = 0; i < L; i++) begin
                m_deb[i]  = 1'b1;
                m_last[i] = t;
            end
            m_press = '0; m_pend = '0; m_ovf = 1'b0; m_valid = 1'b0;
            m_lane = 0; m_rr = 0; m_ledS = '1; m_ledR = '1;
            pend_h.push_back('0);
        end else begin
            acc = '0;
            if (m_valid && hit_ready) acc[m_lane] = 1'b1;
            ovf_n = 1'b0;
            for (int i = 0; i < L; i++) begin
                if (m_press[i]) begin
                    np[i] = 1'b1;
                    if (m_pend[i] && !acc[i]) ovf_n = 1'b1;
                end else if (acc[i]) begin
                    np[i] = 1'b0;
                end else begin
                    np[i] = m_pend[i];
                end
            end
            v_n = m_valid; lane_n = m_lane; rr_n = m_rr;
            if (!m_valid) begin
                for (int k = 0; k < L; k++) begin
                    if (!v_n && m_pend[(m_rr + k) % L]) begin
                        v_n = 1'b1;
                        lane_n = (m_rr + k) % L;
                    end
                end
            end else if (hit_ready) begin
                v_n = 1'b0;
                rr_n = (m_lane + 1) % L;
            end
            if (rst_h[t-1]) begin
                ls = '1; lr = '0;
            end else begin
                for (int i = 0; i < L; i++) begin
                    ls[i] = !(m_pend[i] && !pend_h[t-2][i]);
                    lr[i] = !(pend_h[t-2][i] && !m_pend[i]);
                end
            end
            pr_n = '0;
            for (int i = 0; i < L; i++) begin
                flip = 1'b0;
                if (t - m_last[i] >= DB) begin
                    flip = 1'b1;
                    for (int j = 0; j < DB; j++)
                        if (sync_at(t - j, i) == m_deb[i]) flip = 1'b0;
                end
                if (flip) begin
                    m_deb[i]  = !m_deb[i];
                    m_last[i] = t;
                    pr_n[i]   = !m_deb[i];
                end
            end
            m_press = pr_n; m_pend = np; m_ovf = ovf_n;
            m_valid = v_n; m_lane = lane_n; m_rr = rr_n;
            m_ledS = ls; m_ledR = lr;
            pend_h.push_back(np);
        end
        cyc++;
    endfunction

    // ---------------- observation counters ----------------
    int           acc_log[$];
    int           ovf_cnt;
    int           rise_cnt[L];
    int           s_cnt[L];
    int           r_cnt[L];
    logic [L-1:0] prev_pend = '0;

    task automatic clear_counts();
        ovf_cnt = 0;
        for (int i = 0; i < L; i++) begin
            rise_cnt[i] = 0; s_cnt[i] = 0; r_cnt[i] = 0;
        end
    endtask

    // One clock: log handshake, advance model on posedge, compare on negedge.
    task automatic tick();
        if (notRst && hit_valid === 1'b1 && hit_ready) acc_log.push_back(int'(hit_lane));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("hit_valid", 32'(hit_valid), 32'(m_valid));
        if (m_valid) check("hit_lane", 32'(hit_lane), m_lane);
        check("pending", 32'(pending), 32'(m_pend));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("led_notS", 32'(led_notS), 32'(m_ledS));
        check("led_notR", 32'(led_notR), 32'(m_ledR));
        if (overflow) ovf_cnt++;
        for (int i = 0; i < L; i++) begin
            if (pending[i] && !prev_pend[i]) rise_cnt[i]++;
            if (!led_notS[i]) s_cnt[i]++;
            if (!led_notR[i]) r_cnt[i]++;
        end
        prev_pend = pending;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        notRst = 1'b0; hit_ready = 1'b0; key_n = '1;
        run(3);
        notRst = 1'b1;
        run(2);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (hit_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit found;
        int hold[L];

        // 1: reset state and latch-clear pulse
        clear_counts();
        notRst = 1'b0;
        run(3);
        check("rst_valid", 32'(hit_valid), 32'd0);
        check("rst_lane", 32'(hit_lane), 32'd0);
        check("rst_notR", 32'(led_notR), 32'hF);
        notRst = 1'b1;
        tick();
        check("init_notR", 32'(led_notR), 32'h0);
        check("init_notS", 32'(led_notS), 32'hF);
        check("init_pending", 32'(pending), 32'h0);
        check("init_overflow", 32'(overflow), 32'd0);
        tick();
        check("init_notR_end", 32'(led_notR), 32'hF);

        // 2: bouncing lane 1 produces exactly one press
        do_reset();
        clear_counts();
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) key_n[1] = ~key_n[1];
            tick();
        end
        check("bounce_no_press", 32'(pending), 32'h0);
        key_n[1] = 1'b0;
        lat = 0;
        found = 1'b0;
        for (int k = 0; k < DB + 12; k++) begin
            tick();
            lat++;
            if (hit_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("bounce_valid", 32'(found), 32'd1);
        check("bounce_lat_ok", 32'(lat >= DB + 2 && lat <= DB + 6), 32'd1);
        check("bounce_lane", 32'(hit_lane), 32'd1);
        check("bounce_pending", 32'(pending), 32'b0010);
        check("bounce_rises", 32'(rise_cnt[1]), 32'd1);
        hit_ready = 1'b1;
        run(2);
        hit_ready = 1'b0;
        key_n[1] = 1'b1;
        run(DB + 6);

        // 3: fairness
        do_reset();
        acc_log.delete();
        hit_ready = 1'b1;
        key_n = 4'b0010;
        run(DB + 20);
        check("fair_n", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() == 3) begin
            check("fair_0", 32'(acc_log[0]), 32'd0);
            check("fair_1", 32'(acc_log[1]), 32'd2);
            check("fair_2", 32'(acc_log[2]), 32'd3);
        end
        hit_ready = 1'b0;
        key_n = '1;
        run(DB + 6);
        acc_log.delete();
        key_n = 4'b0110;
        run(DB + 6);
        hit_ready = 1'b1;
        run(6);
        check("fair2_n", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() == 2) begin
            check("fair2_0", 32'(acc_log[0]), 32'd0);
            check("fair2_1", 32'(acc_log[1]), 32'd3);
        end
        hit_ready = 1'b0;
        key_n = '1;
        run(DB + 6);

        // 4: backpressure and overflow
        do_reset();
        key_n[2] = 1'b0;
        wait_valid("bp_valid", DB + 10);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("bp_hold_valid", 32'(hit_valid), 32'd1);
            check("bp_hold_lane", 32'(hit_lane), 32'd2);
        end
        key_n[2] = 1'b1;
        run(DB + 6);
        clear_counts();
        key_n[2] = 1'b0;
        run(DB + 8);
        check("bp_ovf_once", 32'(ovf_cnt), 32'd1);
        check("bp_pending2", 32'(pending[2]), 32'd1);
        check("bp_lane", 32'(hit_lane), 32'd2);
        hit_ready = 1'b1;
        run(3);
        hit_ready = 1'b0;
        key_n = '1;
        run(DB + 6);

        // 5: press event of lane 0 in its own accept cycle
        do_reset();
        key_n[0] = 1'b0;
        wait_valid("sim_valid", DB + 10);
        check("sim_lane", 32'(hit_lane), 32'd0);
        key_n[0] = 1'b1;
        run(DB + 6);
        key_n[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < DB + 10; k++) begin
            tick();
            if (m_press[0]) begin
                found = 1'b1;
                break;
            end
        end
        check("sim_press_seen", 32'(found), 32'd1);
        clear_counts();
        hit_ready = 1'b1;
        tick();
        hit_ready = 1'b0;
        run(4);
        check("sim_pending0", 32'(pending[0]), 32'd1);
        check("sim_no_ovf", 32'(ovf_cnt), 32'd0);
        check("sim_no_notS0", 32'(s_cnt[0]), 32'd0);
        check("sim_no_notR0", 32'(r_cnt[0]), 32'd0);
        check("sim_reoffer_v", 32'(hit_valid), 32'd1);
        check("sim_reoffer_l", 32'(hit_lane), 32'd0);
        hit_ready = 1'b1;
        run(2);
        hit_ready = 1'b0;
        key_n = '1;
        run(DB + 6);

        // 6: reset while a hit is offered
        do_reset();
        key_n[1] = 1'b0;
        wait_valid("mid_valid", DB + 10);
        notRst = 1'b0;
        tick();
        check("mid_valid_drop", 32'(hit_valid), 32'd0);
        check("mid_pending", 32'(pending), 32'h0);
        notRst = 1'b1;
        key_n = '1;
        run(4);

        // Random phase
        do_reset();
        for (int i = 0; i < L; i++) hold[i] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < L; i++) begin
                if (hold[i] == 0) begin
                    key_n[i] = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 40));
                end else begin
                    hold[i]--;
                end
            end
            hit_ready = ($urandom_range(0, 3) != 0);
            notRst = ($urandom_range(0, 799) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
